// File: rtl/fc_weight_loader.sv
// fc_weight_loader
// Sequences a full weight load into the fully-connected stack. After a start
// pulse it accepts weight words over a valid/ready handshake and steers each
// word to one layer at a time, from layer NumLayers-1 (input side) down to
// layer 0. The number of words taken by layer i is LayerBeats[i].
//
// Ports:
//   clk              - clock, all logic on the rising edge
//   res              - synchronous active-high reset
//   in_start         - single-cycle request to begin a full load (ignored while loading)
//   in_abort         - stop the current load and return to idle
//   in_valid         - source word valid
//   in_weights       - source word, one weight per neuron lane
//   in_ready         - loader accepts a word this cycle
//   out_weights      - registered word to the FC top
//   out_load_weights - one-hot load strobe for the layer receiving out_weights
//   out_layer        - index of the layer currently being loaded
//   out_busy         - high while loading
//   out_done         - single-cycle pulse after the last word of layer 0
module fc_weight_loader #(
  parameter int M_W_BitSize                 = 8,
  parameter int NumLayers                   = 4,
  parameter int MaxNumNerves                = 8,
  parameter int LayerBeats [NumLayers-1:0]  = '{2, 4, 8, 4}
) (
  input  logic                                     clk,
  input  logic                                     res,
  input  logic                                     in_start,
  input  logic                                     in_abort,
  input  logic                                     in_valid,
  input  logic [MaxNumNerves-1:0][M_W_BitSize-1:0] in_weights,
  output logic                                     in_ready,
  output logic [MaxNumNerves-1:0][M_W_BitSize-1:0] out_weights,
  output logic [NumLayers-1:0]                     out_load_weights,
  output logic [(NumLayers > 1 ? $clog2(NumLayers) : 1)-1:0] out_layer,
  output logic                                     out_busy,
  output logic                                     out_done
);

  localparam int LayerW = (NumLayers > 1) ? $clog2(NumLayers) : 1;

  function automatic int max_beats();
    int m;
    m = 1;
    for (int i = 0; i < NumLayers; i++) begin
      if (LayerBeats[i] > m) m = LayerBeats[i];
    end
    return m;
  endfunction

  localparam int CntW = $clog2(max_beats()) + 1;

  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

  state_t                                   state_reg;
  state_t                                   state_next;
  logic [CntW-1:0]                          cnt_reg;
  logic [LayerW-1:0]                        layer_reg;
  logic [MaxNumNerves-1:0][M_W_BitSize-1:0] weights_reg;
  logic [NumLayers-1:0]                     load_reg;
  logic                                     done_reg;

  // Index of the last beat of every layer, checked at elaboration.
  logic [CntW-1:0] last_beat [NumLayers];

  genvar gi;
  generate
    for (gi = 0; gi < NumLayers; gi++) begin : g_beats
      if (LayerBeats[gi] < 1) begin : g_bad_beats
        $error("fc_weight_loader: every LayerBeats entry must be >= 1");
      end
      assign last_beat[gi] = CntW'(LayerBeats[gi] - 1);
    end
  endgenerate

  logic accept;
  logic beat_last;
  logic final_beat;

  assign accept     = in_valid && in_ready;
  assign beat_last  = (cnt_reg == last_beat[layer_reg]);
  assign final_beat = beat_last && (layer_reg == '0);

  // State register
  always_ff @(posedge clk) begin
    if (res) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; abort has priority over start in idle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_start && !in_abort) state_next = LOAD;
      LOAD: begin
        if (in_abort)                  state_next = IDLE;
        else if (accept && final_beat) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Moore-style outputs plus the abort override on ready
  always_comb begin
    in_ready = 1'b0;
    out_busy = 1'b0;
    if (state_reg == LOAD) begin
      in_ready = !in_abort;
      out_busy = 1'b1;
    end
  end

  // Datapath: beat counter, layer index and registered outputs
  always_ff @(posedge clk) begin
    if (res) begin
      cnt_reg     <= '0;
      layer_reg   <= '0;
      weights_reg <= '0;
      load_reg    <= '0;
      done_reg    <= 1'b0;
    end else begin
      // Strobe only in the cycle right after an accepted beat
      load_reg <= accept ? (NumLayers'(1) << layer_reg) : '0;
      done_reg <= accept && final_beat;
      if (accept) weights_reg <= in_weights;

      case (state_reg)
        IDLE: begin
          if (in_start && !in_abort) begin
            cnt_reg   <= '0;
            layer_reg <= LayerW'(NumLayers - 1);
          end
        end
        LOAD: begin
          if (in_abort) begin
            cnt_reg   <= '0;
            layer_reg <= '0;
          end else if (accept) begin
            if (beat_last) begin
              cnt_reg <= '0;
              // Layer 0 is the last one; it stays at 0 on the way back to idle
              if (layer_reg != '0) layer_reg <= layer_reg - LayerW'(1);
            end else begin
              cnt_reg <= cnt_reg + CntW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_weights      = weights_reg;
  assign out_load_weights = load_reg;
  assign out_layer        = layer_reg;
  assign out_done         = done_reg;

endmodule
